// File: rtl/apb4_cmd_master_pkg.sv
// Shared FSM state type and encoding for the APB4 command master.
package apb4_cmd_master_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SETUP  = ST_SETUP,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } state_e;

   function automatic logic is_bus_phase(input state_e s);
      return (s == SETUP) || (s == ACCESS);
   endfunction

endpackage

// File: rtl/apb4_cmd_master_if.sv
// Command/response handshake and APB4 bus bundle; master = the command master's view.
interface apb4_cmd_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic                  cmd_write_i;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [DATA_WIDTH-1:0] cmd_wdata_i;
   logic [STRB_WIDTH-1:0] cmd_strb_i;
   logic [2:0]            cmd_prot_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_err_o;
   logic                  rsp_timeout_o;
   logic [ADDR_WIDTH-1:0] paddr_o;
   logic [2:0]            pprot_o;
   logic                  psel_o;
   logic                  penable_o;
   logic                  pwrite_o;
   logic [DATA_WIDTH-1:0] pwdata_o;
   logic [STRB_WIDTH-1:0] pstrb_o;
   logic                  pready_i;
   logic [DATA_WIDTH-1:0] prdata_i;
   logic                  pslverr_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
      input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
      output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i,
      output rsp_ready_i, pready_i, prdata_i, pslverr_i,
      input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
   );

endinterface

// File: rtl/apb4_cmd_master_tmo.sv
// ACCESS-phase cycle counter; o_last flags the final permitted ACCESS cycle.
module apb4_cmd_master_tmo
   import apb4_cmd_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_count,
   output logic o_last
);
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;

   // Counts completed ACCESS cycles; cleared whenever the FSM is elsewhere.
   assign w_cnt_next = i_count ? (r_cnt + 1'b1) : '0;

   dffr #(.W(CW)) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (w_cnt_next),
      .o_q     (r_cnt)
   );

   assign o_last = i_count && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dffer.sv
// Flip-flop with load enable and asynchronous active-low reset to RST_VAL.
module dffer #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  o_q <= RST_VAL;
      else if (i_en) o_q <= i_d;
   end
endmodule

// File: rtl/dffr.sv
// Flip-flop with asynchronous active-low reset to RST_VAL.
module dffr #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_q <= RST_VAL;
      else          o_q <= i_d;
   end
endmodule

// File: rtl/apb4_cmd_master.sv
// APB4 master driven by a valid/ready command port, one transaction outstanding.
// Optional ACCESS timeout enabled by macro APB4_CMD_MASTER_TIMEOUT_EN.
module apb4_cmd_master
   import apb4_cmd_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   apb4_cmd_master_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   state_e                r_state;
   state_e                w_state_next;
   logic [1:0]            w_state_q;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_tmo;

   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [2:0]            r_pprot;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [STRB_WIDTH-1:0] r_pstrb;
   logic [DATA_WIDTH-1:0] w_wdata_d;
   logic [STRB_WIDTH-1:0] w_strb_d;

   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] w_rdata_d;
   logic                  r_err;
   logic                  r_timeout;

   dffr #(.W(2), .RST_VAL(ST_IDLE)) u_state (
      .i_clk   (clk_i),
      .i_rst_n (rst_n_i),
      .i_d     (w_state_next),
      .o_q     (w_state_q)
   );
   assign r_state = state_e'(w_state_q);

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
   logic w_tmo_last;

   apb4_cmd_master_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .i_clk   (clk_i),
      .i_rst_n (rst_n_i),
      .i_count (r_state == ACCESS),
      .o_last  (w_tmo_last)
   );
   // A pready on the last permitted cycle still completes normally.
   assign w_tmo = w_tmo_last && !bus.pready_i;
`else
   logic w_unused_tmo_cfg;
   assign w_unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
   assign w_tmo            = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               w_accept     = 1'b1;
               w_state_next = SETUP;
            end
         end
         SETUP:  w_state_next = ACCESS;
         ACCESS: begin
            if (bus.pready_i || w_tmo) begin
               w_done       = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Reads present zero write data and strobes on the bus.
   assign w_wdata_d = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
   for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
      assign w_strb_d[gi] = bus.cmd_write_i & bus.cmd_strb_i[gi];
   end

   dffer #(.W(1)) u_pwrite (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_accept), .i_d(bus.cmd_write_i), .o_q(r_pwrite)
   );
   dffer #(.W(ADDR_WIDTH)) u_paddr (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_accept), .i_d(bus.cmd_addr_i), .o_q(r_paddr)
   );
   dffer #(.W(3)) u_pprot (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_accept), .i_d(bus.cmd_prot_i), .o_q(r_pprot)
   );
   dffer #(.W(DATA_WIDTH)) u_pwdata (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_accept), .i_d(w_wdata_d), .o_q(r_pwdata)
   );
   dffer #(.W(STRB_WIDTH)) u_pstrb (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_accept), .i_d(w_strb_d), .o_q(r_pstrb)
   );

   assign w_rdata_d = (r_pwrite || w_tmo) ? '0 : bus.prdata_i;

   dffer #(.W(DATA_WIDTH)) u_rdata (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_done), .i_d(w_rdata_d), .o_q(r_rdata)
   );
   dffer #(.W(1)) u_err (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_done), .i_d(bus.pslverr_i | w_tmo), .o_q(r_err)
   );
   dffer #(.W(1)) u_timeout (
      .i_clk(clk_i), .i_rst_n(rst_n_i), .i_en(w_done), .i_d(w_tmo), .o_q(r_timeout)
   );

   assign bus.cmd_ready_o   = (r_state == IDLE);
   assign bus.psel_o        = is_bus_phase(r_state);
   assign bus.penable_o     = (r_state == ACCESS);
   assign bus.rsp_valid_o   = (r_state == RESP);
   assign bus.paddr_o       = r_paddr;
   assign bus.pprot_o       = r_pprot;
   assign bus.pwrite_o      = r_pwrite;
   assign bus.pwdata_o      = r_pwdata;
   assign bus.pstrb_o       = r_pstrb;
   assign bus.rsp_rdata_o   = r_rdata;
   assign bus.rsp_err_o     = r_err;
   assign bus.rsp_timeout_o = r_timeout;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Randomized self-checking bench for apb4_cmd_master against a transaction-level model.
module tb_apb4_cmd_master;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      bit          slverr;
      logic [31:0] rdata;
      int          rsp_hold;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   apb4_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb4_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // APB inputs outside the completing ACCESS cycle must not matter.
   task automatic noise();
      bus.pready_i  = 1'($urandom);
      bus.prdata_i  = $urandom;
      bus.pslverr_i = 1'($urandom);
   endtask

   function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] s, input int wt, input bit e,
                               input logic [31:0] rd, input int hold);
      txn_t t;
      t.write = w; t.addr = a; t.wdata = wd; t.strb = s; t.prot = 3'($urandom);
      t.waits = wt; t.slverr = e; t.rdata = rd; t.rsp_hold = hold;
      return t;
   endfunction

   // Called at a negedge with the DUT idle.
   task automatic run_txn(input int id, input txn_t t);
      bit          tmo;
      int          n_acc_exp;
      int          n_acc;
      logic [31:0] e_rdata;
      logic [31:0] e_wdata;
      logic [3:0]  e_strb;
      bit          e_err;

      tmo       = TMO_EN && (t.waits >= TMO);
      n_acc_exp = tmo ? TMO : t.waits + 1;
      e_rdata   = (t.write || tmo) ? 32'h0 : t.rdata;
      e_wdata   = t.write ? t.wdata : 32'h0;
      e_strb    = t.write ? t.strb : 4'h0;
      e_err     = tmo || t.slverr;

      check("idle_ready", bus.cmd_ready_o, 1'b1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = t.write;
      bus.cmd_addr_i  = t.addr;
      bus.cmd_wdata_i = t.wdata;
      bus.cmd_strb_i  = t.strb;
      bus.cmd_prot_i  = t.prot;
      noise();
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_addr_i  = $urandom;
      bus.cmd_wdata_i = $urandom;
      bus.cmd_write_i = 1'($urandom);
      check("setup_sel", {bus.psel_o, bus.penable_o, bus.cmd_ready_o}, 3'b100);
      check("setup_addr", bus.paddr_o, t.addr);
      check("setup_ctl", {bus.pwdata_o, bus.pstrb_o, bus.pprot_o, bus.pwrite_o},
            {e_wdata, e_strb, t.prot, t.write});
      noise();

      n_acc = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (!(bus.psel_o && bus.penable_o)) break;
         n_acc++;
         check("acc_addr", bus.paddr_o, t.addr);
         check("acc_ctl", {bus.pwdata_o, bus.pstrb_o, bus.pprot_o, bus.pwrite_o},
               {e_wdata, e_strb, t.prot, t.write});
         if (n_acc - 1 == t.waits) begin
            bus.pready_i  = 1'b1;
            bus.prdata_i  = t.rdata;
            bus.pslverr_i = t.slverr;
         end else begin
            bus.pready_i  = 1'b0;
            bus.prdata_i  = $urandom;
            bus.pslverr_i = 1'($urandom);
         end
      end
      check("n_access", n_acc, n_acc_exp);

      bus.rsp_ready_i = 1'b0;
      for (int h = 0; h <= t.rsp_hold; h++) begin
         if (h > 0) @(negedge clk);
         check("rsp_hold", {bus.rsp_valid_o, bus.cmd_ready_o, bus.psel_o, bus.penable_o,
                            bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_rdata_o},
               {1'b1, 1'b0, 1'b0, 1'b0, e_err, tmo, e_rdata});
         noise();
         bus.cmd_valid_i = 1'($urandom);
      end
      bus.cmd_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      check("rsp_done", {bus.rsp_valid_o, bus.cmd_ready_o, bus.psel_o}, 3'b010);
      $display("txn %0d: %s addr=0x%08h waits=%0d rdata=0x%08h err=%0b tmo=%0b",
               id, t.write ? "WR" : "RD", t.addr, t.waits, bus.rsp_rdata_o,
               bus.rsp_err_o, bus.rsp_timeout_o);
   endtask

   initial begin
      txn_t t;
      bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
      bus.cmd_wdata_i = '0;   bus.cmd_strb_i  = '0;   bus.cmd_prot_i = '0;
      bus.rsp_ready_i = 1'b0; bus.pready_i    = 1'b0; bus.prdata_i   = '0;
      bus.pslverr_i   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {bus.cmd_ready_o, bus.rsp_valid_o, bus.psel_o, bus.penable_o,
                        bus.pwrite_o, bus.pprot_o, bus.pstrb_o, bus.rsp_err_o, bus.rsp_timeout_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 4'h0, 1'b0, 1'b0});
      check("rst_data", {bus.paddr_o, bus.pwdata_o}, 64'h0);
      check("rst_rdata", bus.rsp_rdata_o, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(0, mk(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0));
      run_txn(1, mk(1'b0, 32'h14, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678, 0));
      run_txn(2, mk(1'b0, 32'h18, 32'h0, 4'h0, 1, 1'b1, 32'h0BAD_0BAD, 1));
      run_txn(3, mk(1'b0, 32'h1C, 32'h0, 4'h0, TMO, 1'b0, 32'h5555_AAAA, 0));
      run_txn(4, mk(1'b0, 32'h20, 32'h0, 4'h0, TMO - 1, 1'b0, 32'h7777_1111, 0));
      run_txn(5, mk(1'b1, 32'h24, 32'hCAFE_F00D, 4'h5, 0, 1'b0, 32'h0, 5));
      run_txn(6, mk(1'b1, 32'h28, 32'h1111_2222, 4'h3, 12, 1'b0, 32'h0, 0));

      // Reset during ACCESS: bus drops at once, response is discarded.
      bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 32'h30;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0; bus.pready_i = 1'b0;
      @(negedge clk);
      check("pre_rst_access", {bus.psel_o, bus.penable_o}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("rst_async", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.cmd_ready_o}, 4'b0001);
      @(negedge clk);
      bus.pready_i = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.cmd_ready_o}, 4'b0001);
      end

      for (int i = 0; i < 25; i++) begin
         t = mk(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 6),
                1'($urandom), $urandom, $urandom_range(0, 3));
         run_txn(10 + i, t);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
